cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_pkg.sv | 28 ++
 rtl/cmd_frame_parser_if.sv | 22 ++
 rtl/frame_timeout_ctr.sv | 30 +++
 rtl/cmd_frame_parser.sv | 135 +++++++++++++
 tb/tb_cmd_frame_parser.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_frame_pkg.sv
// rtl/cmd_frame_pkg.sv - shared types and constants for the command frame parser
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_TRAIL   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TRAILER = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hAA;
  localparam logic [7:0] DEF_TRL_BYTE = 8'h55;
  localparam int         TIMEOUT_W    = 24;

  // Payload index width; a single-byte payload still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// rtl/cmd_frame_parser_if.sv - byte input and decoded frame outputs of the parser
interface cmd_frame_parser_if #(
  parameter int PAYLOAD_BYTES = 2
);
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic [7:0]                 exp_sel;
  logic [8*PAYLOAD_BYTES-1:0] logic_in;
  logic                       frame_valid;
  logic                       frame_err;
  logic [1:0]                 err_code;

  modport master (
    output rx_data, rx_valid,
    input  exp_sel, logic_in, frame_valid, frame_err, err_code
  );

  modport slave (
    input  rx_data, rx_valid,
    output exp_sel, logic_in, frame_valid, frame_err, err_code
  );
endinterface

// File: rtl/frame_timeout_ctr.sv
// rtl/frame_timeout_ctr.sv - inter-byte gap counter that flags a stalled frame
module frame_timeout_ctr
  import cmd_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // Flags the cycle in which the count would reach TIMEOUT_CYC; a byte in that
  // same cycle asserts clear and wins.
  assign expired = enable && !clear && (count == LAST_CNT);

endmodule

// File: rtl/cmd_frame_parser.sv
// rtl/cmd_frame_parser.sv - UART command frame parser with checksum and timeout
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 2,
  parameter logic [7:0] HDR_BYTE      = DEF_HDR_BYTE,
  parameter logic [7:0] TRL_BYTE      = DEF_TRL_BYTE,
  parameter bit         CSUM_EN       = 1'b1,
  parameter int         TIMEOUT_CYC   = 1_000_000
) (
  input logic                tclk,
  input logic                rst,
  cmd_frame_parser_if.slave  bus
);

  localparam int                CNT_W    = idx_width(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

  state_t                     state;
  logic [CNT_W-1:0]           byte_cnt;
  logic [7:0]                 csum;
  logic [7:0]                 sel_sh;
  logic [7:0]                 pay_sh [PAYLOAD_BYTES];
  logic [8*PAYLOAD_BYTES-1:0] pay_vec;

  logic [7:0]                 exp_sel_r;
  logic [8*PAYLOAD_BYTES-1:0] logic_in_r;
  logic                       frame_valid_r;
  logic                       frame_err_r;
  logic [1:0]                 err_code_r;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       expired;

  assign rx_data  = bus.rx_data;
  assign rx_valid = bus.rx_valid;

  frame_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (tclk),
    .rst     (rst),
    .clear   (rx_valid || (state == ST_IDLE)),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  // First received payload byte lands in the most significant byte.
  always_comb begin
    pay_vec = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      pay_vec[8*(PAYLOAD_BYTES-1-i) +: 8] = pay_sh[i];
    end
  end

  always_ff @(posedge tclk) begin
    if (rst) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      csum          <= '0;
      sel_sh        <= '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
        pay_sh[i] <= '0;
      end
      exp_sel_r     <= '0;
      logic_in_r    <= '0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      err_code_r    <= ERR_NONE;
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            byte_cnt <= '0;
            if (rx_data == HDR_BYTE) begin
              state <= ST_SEL;
            end
          end
          ST_SEL: begin
            sel_sh   <= rx_data;
            csum     <= rx_data;
            byte_cnt <= '0;
            state    <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            pay_sh[byte_cnt] <= rx_data;
            csum             <= csum ^ rx_data;
            if (byte_cnt == LAST_IDX) begin
              byte_cnt <= '0;
              state    <= CSUM_EN ? ST_CSUM : ST_TRAIL;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
          ST_CSUM: begin
            if (rx_data != csum) begin
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_CSUM;
              state       <= ST_IDLE;
            end else begin
              state <= ST_TRAIL;
            end
          end
          ST_TRAIL: begin
            if (rx_data == TRL_BYTE) begin
              exp_sel_r     <= sel_sh;
              logic_in_r    <= pay_vec;
              frame_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_TRAILER;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (expired) begin
        frame_err_r <= 1'b1;
        err_code_r  <= ERR_TIMEOUT;
        byte_cnt    <= '0;
        state       <= ST_IDLE;
      end
    end
  end

  assign bus.exp_sel     = exp_sel_r;
  assign bus.logic_in    = logic_in_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.err_code    = err_code_r;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb/tb_cmd_frame_parser.sv - scoreboard bench for three parser configurations
module tb_cmd_frame_parser;

  typedef struct packed {
    logic [1:0]  dut;
    logic [1:0]  kind;
    logic [7:0]  sel;
    logic [31:0] li;
    logic [1:0]  ec;
  } ev_t;

  logic       tclk = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  int         tgt = 0;
  int         checks = 0;
  int         errors = 0;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [1:0] mon_kind;
  logic [7:0] m_sel [3];
  logic [31:0] m_li [3];
  logic [1:0] m_ec [3];

  logic        fv [3];
  logic        fe [3];
  logic [7:0]  sel_w [3];
  logic [31:0] li_w [3];
  logic [1:0]  ec_w [3];

  always #5 tclk = ~tclk;

  cmd_frame_parser_if #(.PAYLOAD_BYTES(2)) if_def ();
  cmd_frame_parser_if #(.PAYLOAD_BYTES(2)) if_to ();
  cmd_frame_parser_if #(.PAYLOAD_BYTES(4)) if_p4 ();

  assign if_def.rx_data  = rx_data;
  assign if_def.rx_valid = rx_valid && (tgt == 0);
  assign if_to.rx_data   = rx_data;
  assign if_to.rx_valid  = rx_valid && (tgt == 1);
  assign if_p4.rx_data   = rx_data;
  assign if_p4.rx_valid  = rx_valid && (tgt == 2);

  cmd_frame_parser u_def (.tclk(tclk), .rst(rst), .bus(if_def));
  cmd_frame_parser #(.TIMEOUT_CYC(100)) u_to (.tclk(tclk), .rst(rst), .bus(if_to));
  cmd_frame_parser #(.PAYLOAD_BYTES(4), .CSUM_EN(1'b0)) u_p4 (.tclk(tclk), .rst(rst), .bus(if_p4));

  assign fv[0] = if_def.frame_valid;  assign fe[0] = if_def.frame_err;
  assign fv[1] = if_to.frame_valid;   assign fe[1] = if_to.frame_err;
  assign fv[2] = if_p4.frame_valid;   assign fe[2] = if_p4.frame_err;
  assign sel_w[0] = if_def.exp_sel;   assign li_w[0] = {16'h0, if_def.logic_in};
  assign sel_w[1] = if_to.exp_sel;    assign li_w[1] = {16'h0, if_to.logic_in};
  assign sel_w[2] = if_p4.exp_sel;    assign li_w[2] = if_p4.logic_in;
  assign ec_w[0] = if_def.err_code;   assign ec_w[1] = if_to.err_code;
  assign ec_w[2] = if_p4.err_code;

  // Pulse monitor: each frame_valid/frame_err pops the next expected event.
  always @(negedge tclk) begin
    for (int d = 0; d < 3; d++) begin
      if (fv[d] === 1'b1 || fe[d] === 1'b1) begin
        mon_kind = {fe[d], fv[d]};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse dut=%0d err/valid=%b required no pulse", d, mon_kind);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.dut !== 2'(d) || mon_e.kind !== mon_kind || mon_e.sel !== sel_w[d] ||
              mon_e.li !== li_w[d] || mon_e.ec !== ec_w[d]) begin
            errors++;
            $display("FAIL pulse dut=%0d kind=%b sel=%h li=%h ec=%0d required dut=%0d kind=%b sel=%h li=%h ec=%0d",
                     d, mon_kind, sel_w[d], li_w[d], ec_w[d],
                     mon_e.dut, mon_e.kind, mon_e.sel, mon_e.li, mon_e.ec);
          end
        end
      end
    end
  end

  function automatic void push_valid(input int d, input logic [7:0] s, input logic [31:0] l);
    m_sel[d] = s;
    m_li[d]  = l;
    exp_q.push_back({2'(d), 2'b01, s, l, m_ec[d]});
  endfunction

  function automatic void push_err(input int d, input logic [1:0] c);
    m_ec[d] = c;
    exp_q.push_back({2'(d), 2'b10, m_sel[d], m_li[d], c});
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_sel[d] = 8'h00;
      m_li[d]  = 32'h0;
      m_ec[d]  = 2'd0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge tclk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge tclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    idle(3);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({sel_w[d], li_w[d], fv[d], fe[d], ec_w[d]} !== 44'h0) begin
        errors++;
        $display("FAIL reset_values dut=%0d sel=%h li=%h fv=%b fe=%b ec=%0d required all zero",
                 d, sel_w[d], li_w[d], fv[d], fe[d], ec_w[d]);
      end
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame();
    tgt = 0;
    push_valid(0, 8'h11, 32'h0003);
    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_frame_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bad_csum();
    tgt = 0;
    push_err(0, 2'd2);
    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h13); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_csum_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (sel_w[0] !== 8'h11 || li_w[0] !== 32'h0003) begin
      errors++;
      $display("FAIL bad_csum_hold sel=%h li=%h required sel=11 li=00000003", sel_w[0], li_w[0]);
    end
  endtask

  task automatic test_bad_trailer();
    tgt = 0;
    push_err(0, 2'd1);
    send_byte(8'hAA); send_byte(8'h22); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h21); send_byte(8'h56);
    push_valid(0, 8'h22, 32'h0102);
    send_byte(8'hAA); send_byte(8'h22); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h21); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_trailer_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (ec_w[0] !== 2'd1) begin
      errors++;
      $display("FAIL err_code_hold ec=%0d required 1", ec_w[0]);
    end
  endtask

  task automatic test_noise();
    tgt = 0;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hFF);
    idle(2);
    push_valid(0, 8'h33, 32'h0405);
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h32); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL noise_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_hdr_as_data();
    tgt = 0;
    push_valid(0, 8'hAA, 32'hAAAA);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hAA);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hdr_as_data_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    tgt = 0;
    push_valid(0, 8'h01, 32'h0203);
    push_valid(0, 8'h04, 32'h0506);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h55);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h06); send_byte(8'h07); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_payload4();
    tgt = 2;
    push_valid(2, 8'h33, 32'hDEADBEEF);
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL payload4_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    tgt = 1;
    send_byte(8'hAA); send_byte(8'h11);
    idle(99);
    push_err(1, 2'd3);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    push_valid(1, 8'h11, 32'h0003);
    send_byte(8'hAA); send_byte(8'h11);
    idle(99);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h12); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_edge_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    tgt = 0;
    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h00);
    rst = 1'b1;
    model_reset();
    send_byte(8'hAA); send_byte(8'h55);
    rst = 1'b0;
    idle(2);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({sel_w[d], li_w[d], fv[d], fe[d], ec_w[d]} !== 44'h0) begin
        errors++;
        $display("FAIL reset_mid dut=%0d sel=%h li=%h fv=%b fe=%b ec=%0d required all zero",
                 d, sel_w[d], li_w[d], fv[d], fe[d], ec_w[d]);
      end
    end
    push_valid(0, 8'h11, 32'h0003);
    send_byte(8'hAA); send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h55);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_trailer();
    test_noise();
    test_hdr_as_data();
    test_back_to_back();
    test_payload4();
    test_timeout();
    test_reset_mid();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
